data_memo_ctrl: RTL and testbench
=================================

Name: data_memo_ctrl

Overview:
Sequencer and arbiter in front of the data memory block, which has a static array (memoR/memoWR) and a hardware stack (push/pop).
It shares the memory between two requesters:
- the load/store unit (ls_*)
- the call/return stack unit (st_*)
It issues exactly one memory command per transaction and tracks stack occupancy itself, so full/empty errors are detected before a command is issued.
Both requesters use a req/ack handshake: the requester holds req until ack.

Parameters:
ADDR_W, 32, width of static-memory address
DATA_W, 32, data width
SP_W, 9, width of stack occupancy counter
STACK_MAX, 511, maximum stack entries (matches memory DEPTH)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
ls_req  in  1  load/store request, held until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  static address
ls_wdata  in  DATA_W  store data
ls_ack  out  1  one-cycle completion pulse
ls_rdata  out  DATA_W  load data, valid while ls_ack=1
st_req  in  1  stack request, held until st_ack
st_push  in  1  1 = push, 0 = pop
st_wdata  in  DATA_W  push data
st_ack  out  1  one-cycle completion pulse
st_rdata  out  DATA_W  popped data, valid while st_ack=1
st_err  out  1  with st_ack: push-on-full or pop-on-empty, no command issued
mem_address  out  ADDR_W  to memory address
mem_dataIn  out  DATA_W  to memory dataIn
mem_memoR, mem_memoWR, mem_push, mem_pop  out  1 each  command strobes, at most one high
mem_dataOut  in  DATA_W  from memory dataOut
busy  out  1  FSM not in IDLE
sp_count  out  SP_W  current stack occupancy

Behaviour:
- Reset (async, takes effect immediately):
  - FSM returns to IDLE.
  - All strobes, acks and st_err go 0; ls_rdata/st_rdata go 0.
  - sp_count goes 0; last_grant goes ST, so LS wins the first tie.
  - rst must be the system reset: the memory has no reset and must start empty.
- All outputs are registered. mem_address/mem_dataIn hold the captured request values from CMD through RESP.
- IDLE:
  - Sample ls_req/st_req.
  - Both high: grant the one opposite to last_grant. One high: grant it.
  - Capture op, address and data; update last_grant; go CMD.
- CMD (one cycle):
  - Store: mem_memoWR=1 → RESP.
  - Load: mem_memoR=1 → WAIT.
  - Push with sp_count==STACK_MAX: no strobe, err flag set → RESP.
  - Push otherwise: mem_push=1, sp_count+1 at cycle end → RESP.
  - Pop with sp_count==0: no strobe, err flag set → RESP.
  - Pop otherwise: mem_pop=1, sp_count−1 at cycle end; capture mem_dataOut (current top of stack) at the end of CMD → RESP.
- WAIT (one cycle, loads only):
  - Memory registers read data at the end of CMD.
  - Capture mem_dataOut at the end of WAIT → RESP.
- RESP (one cycle):
  - Pulse ls_ack or st_ack for the granted requester. st_err is valid with st_ack.
  - Present captured rdata → IDLE.
- Latency, with req sampled at the end of cycle 0:
  - strobe in cycle 1
  - ack in cycle 2 for store/push/pop/error
  - ack in cycle 3 for load
- Requester drops req in the cycle after ack. A req still high at the next IDLE sample is a new transaction.
- A requester not granted keeps req high and is served next. Round-robin guarantees at most one transaction of wait.
- sp_count never wraps: saturation is enforced by the error path, and an error never changes sp_count.
- Changes to request inputs while busy are ignored; only captured values are used.
- rdata of the non-granted side holds its previous value.

Decomposition:
- Package data_memo_pkg:
  - state enum {IDLE, CMD, WAIT, RESP}
  - op enum {OP_LOAD, OP_STORE, OP_PUSH, OP_POP}
  - grant enum {GNT_LS, GNT_ST}
  - STACK_MAX constant
- Sub-module rr_arb2: 2-requester round-robin arbiter with a last_grant register.
- FSM and datapath stay in data_memo_ctrl.

Test Plan:
- Store then load: ls store addr 5 data 0xDEADBEEF, then load addr 5.
  - mem_memoWR for exactly 1 cycle, ls_ack in cycle 2.
  - load ls_ack in cycle 3 with ls_rdata=0xDEADBEEF.
- Push then pop: push 42, then push 7, then pop, then pop.
  - st_rdata=7 then 42; sp_count 1,2,1,0.
  - st_err=0 throughout; mem_push/mem_pop 1 cycle each.
- Empty pop: pop at reset → st_ack with st_err=1, no strobe, sp_count stays 0.
- Full push: 511 pushes reach sp_count=511; the 512th push → st_err=1, no mem_push, count stays 511.
- Simultaneous requests: ls_req and st_req high together for 4 transactions.
  - Grants alternate LS, ST, LS, ST.
  - Never two strobes high at once.
- Reset mid-operation: assert rst during WAIT of a load → strobes/acks go 0 immediately, busy=0, sp_count=0, no ack after release.

Source files
------------

// File: rtl/data_memo_pkg.sv
// Shared types for the data-memory sequencer: FSM states, memory operations
// and arbiter grant identifiers.
package data_memo_pkg;

  localparam int unsigned STACK_MAX = 511;

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_t;
  typedef enum logic {GNT_LS, GNT_ST} grant_t;

endpackage

// File: rtl/data_memo_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the side opposite to the last
// accepted grant wins.
module rr_arb2
  import data_memo_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_ls_i,
  input  logic   req_st_i,
  input  logic   accept_i,
  output logic   valid_o,
  output grant_t gnt_o
);

  grant_t last_q;

  always_comb begin
    valid_o = req_ls_i | req_st_i;
    if (req_ls_i && req_st_i) gnt_o = (last_q == GNT_ST) ? GNT_LS : GNT_ST;
    else if (req_ls_i)        gnt_o = GNT_LS;
    else                      gnt_o = GNT_ST;
  end

  // Starting at ST lets the load/store side win the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       last_q <= GNT_ST;
    else if (accept_i && valid_o)  last_q <= gnt_o;
  end

endmodule

// File: rtl/data_memo_ctrl.sv
// Sequencer/arbiter in front of the data memory: one command per transaction,
// stack occupancy tracked locally so full/empty errors never reach memory.
//
// state | meaning
// IDLE  | sample requests, grant, capture op/address/data
// CMD   | drive the single memory strobe (or none on stack error)
// WAIT  | load only: memory read data settles, captured at cycle end
// RESP  | ack pulse to the granted requester with rdata/err
module data_memo_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SP_W      = 9,
  parameter int STACK_MAX = data_memo_pkg::STACK_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic              st_req,
  input  logic              st_push,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_ack,
  output logic [DATA_W-1:0] st_rdata,
  output logic              st_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_memoR,
  output logic              mem_memoWR,
  output logic              mem_push,
  output logic              mem_pop,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              busy,
  output logic [SP_W-1:0]   sp_count
);
  import data_memo_pkg::*;

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_MAX);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  grant_t            gnt_q, gnt_d, arb_gnt;
  logic              arb_valid, arb_accept;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              rd_q, rd_d, wr_q, wr_d, push_q, push_d, pop_q, pop_d;
  logic              ls_ack_q, ls_ack_d, st_ack_q, st_ack_d, st_err_q, st_err_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d, st_rdata_q, st_rdata_d;
  logic              busy_q;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_ls_i (ls_req),
    .req_st_i (st_req),
    .accept_i (arb_accept),
    .valid_o  (arb_valid),
    .gnt_o    (arb_gnt)
  );

  // Strobes, acks and rdata are computed one cycle ahead so every output is a flop.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    sp_d       = sp_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    ls_ack_d   = 1'b0;
    st_ack_d   = 1'b0;
    st_err_d   = 1'b0;
    ls_rdata_d = ls_rdata_q;
    st_rdata_d = st_rdata_q;
    arb_accept = 1'b0;
    case (state_q)
      IDLE: if (arb_valid) begin
        arb_accept = 1'b1;
        gnt_d      = arb_gnt;
        state_d    = CMD;
        if (arb_gnt == GNT_LS) begin
          op_d    = ls_we ? OP_STORE : OP_LOAD;
          addr_d  = ls_addr;
          wdata_d = ls_wdata;
          err_d   = 1'b0;
        end else begin
          op_d    = st_push ? OP_PUSH : OP_POP;
          addr_d  = '0;
          wdata_d = st_wdata;
          err_d   = st_push ? (sp_q == SP_FULL) : (sp_q == '0);
        end
        case (op_d)
          OP_LOAD:  rd_d   = 1'b1;
          OP_STORE: wr_d   = 1'b1;
          OP_PUSH:  push_d = ~err_d;
          OP_POP:   pop_d  = ~err_d;
          default:  ;
        endcase
      end
      CMD: begin
        if (op_q == OP_LOAD) begin
          state_d = WAIT;
        end else begin
          state_d = RESP;
          if (gnt_q == GNT_LS) begin
            ls_ack_d = 1'b1;
          end else begin
            st_ack_d = 1'b1;
            st_err_d = err_q;
          end
          if (op_q == OP_PUSH && !err_q) sp_d = sp_q + SP_W'(1);
          if (op_q == OP_POP && !err_q) begin
            sp_d       = sp_q - SP_W'(1);
            st_rdata_d = mem_dataOut;
          end
        end
      end
      WAIT: begin
        state_d    = RESP;
        ls_ack_d   = 1'b1;
        ls_rdata_d = mem_dataOut;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_LOAD;
      gnt_q      <= GNT_ST;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      sp_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      ls_ack_q   <= 1'b0;
      st_ack_q   <= 1'b0;
      st_err_q   <= 1'b0;
      ls_rdata_q <= '0;
      st_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      sp_q       <= sp_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      ls_ack_q   <= ls_ack_d;
      st_ack_q   <= st_ack_d;
      st_err_q   <= st_err_d;
      ls_rdata_q <= ls_rdata_d;
      st_rdata_q <= st_rdata_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign ls_ack      = ls_ack_q;
  assign ls_rdata    = ls_rdata_q;
  assign st_ack      = st_ack_q;
  assign st_rdata    = st_rdata_q;
  assign st_err      = st_err_q;
  assign mem_address = addr_q;
  assign mem_dataIn  = wdata_q;
  assign mem_memoR   = rd_q;
  assign mem_memoWR  = wr_q;
  assign mem_push    = push_q;
  assign mem_pop     = pop_q;
  assign busy        = busy_q;
  assign sp_count    = sp_q;

endmodule

// File: tb/tb_data_memo_ctrl.sv
// Directed bench for data_memo_ctrl with a behavioural static array + stack
// memory model behind the command strobes.
module tb_data_memo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        ls_ack;
  logic        st_req, st_push;
  logic [31:0] st_wdata, st_rdata;
  logic        st_ack, st_err;
  logic [31:0] mem_address, mem_dataIn, mem_dataOut;
  logic        mem_memoR, mem_memoWR, mem_push, mem_pop;
  logic        busy;
  logic [8:0]  sp_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  data_memo_ctrl dut (
    .clk(clk), .rst(rst),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .st_req(st_req), .st_push(st_push), .st_wdata(st_wdata),
    .st_ack(st_ack), .st_rdata(st_rdata), .st_err(st_err),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_memoR(mem_memoR), .mem_memoWR(mem_memoWR), .mem_push(mem_push), .mem_pop(mem_pop),
    .mem_dataOut(mem_dataOut), .busy(busy), .sp_count(sp_count)
  );

  // Memory model: registered static read, combinational top-of-stack while popping.
  logic [31:0] sarr [0:255];
  logic [31:0] stk  [0:511];
  logic [9:0]  sp_m;
  logic [9:0]  sp_top;
  logic [31:0] rd_m;
  assign sp_top      = sp_m - 10'd1;
  assign mem_dataOut = (mem_pop && sp_m != 10'd0) ? stk[sp_top[8:0]] : rd_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_m <= 10'd0;
      rd_m <= 32'd0;
    end else begin
      if (mem_memoWR) sarr[mem_address[7:0]] <= mem_dataIn;
      if (mem_memoR)  rd_m <= sarr[mem_address[7:0]];
      if (mem_push) begin
        stk[sp_m[8:0]] <= mem_dataIn;
        sp_m <= sp_m + 10'd1;
      end
      if (mem_pop) sp_m <= sp_m - 10'd1;
    end
  end

  int n_rd = 0, n_wr = 0, n_push = 0, n_pop = 0;
  logic multi_strobe = 1'b0;
  always @(negedge clk) begin
    if (mem_memoR)  n_rd++;
    if (mem_memoWR) n_wr++;
    if (mem_push)   n_push++;
    if (mem_pop)    n_pop++;
    if ((32'(mem_memoR) + 32'(mem_memoWR) + 32'(mem_push) + 32'(mem_pop)) > 1) multi_strobe = 1'b1;
  end

  // Stimulus: one idle cycle, raise req, wait (bounded) for ack, drop req.
  task automatic ls_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output int scyc, output logic [31:0] rd);
    lat = -1; scyc = -1; rd = '0;
    @(posedge clk); #1;
    ls_we = we; ls_addr = addr; ls_wdata = wd; ls_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (scyc < 0 && (mem_memoR | mem_memoWR | mem_push | mem_pop)) scyc = n;
      if (ls_ack) begin lat = n; rd = ls_rdata; break; end
    end
    ls_req = 1'b0;
  endtask

  task automatic st_txn(input logic push, input logic [31:0] wd,
                        output int lat, output int scyc, output logic [31:0] rd, output logic err);
    lat = -1; scyc = -1; rd = '0; err = 1'bx;
    @(posedge clk); #1;
    st_push = push; st_wdata = wd; st_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (scyc < 0 && (mem_memoR | mem_memoWR | mem_push | mem_pop)) scyc = n;
      if (st_ack) begin lat = n; rd = st_rdata; err = st_err; break; end
    end
    st_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    st_req = 0; st_push = 0; st_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if ({mem_memoR, mem_memoWR, mem_push, mem_pop} !== 4'b0) $display("FAIL reset_strobes got %b want 0000", {mem_memoR, mem_memoWR, mem_push, mem_pop}); else pass_cnt++;
    total_cnt++; if ({ls_ack, st_ack, st_err, busy} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {ls_ack, st_ack, st_err, busy}); else pass_cnt++;
    total_cnt++; if (sp_count !== 9'd0) $display("FAIL reset_sp got %0d want 0", sp_count); else pass_cnt++;
    total_cnt++; if (ls_rdata !== 32'd0 || st_rdata !== 32'd0) $display("FAIL reset_rdata got %h/%h want 0/0", ls_rdata, st_rdata); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    int lat, scyc, w0, r0;
    logic [31:0] rd;
    w0 = n_wr; r0 = n_rd;
    ls_txn(1'b1, 32'd5, 32'hDEADBEEF, lat, scyc, rd);
    total_cnt++; if (lat !== 2) $display("FAIL store_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (scyc !== 1) $display("FAIL store_strobe_cycle got %0d want 1", scyc); else pass_cnt++;
    total_cnt++; if (n_wr - w0 !== 1) $display("FAIL store_wr_cycles got %0d want 1", n_wr - w0); else pass_cnt++;
    ls_txn(1'b1, 32'd9, 32'h12345678, lat, scyc, rd);
    ls_txn(1'b0, 32'd5, 32'h0, lat, scyc, rd);
    total_cnt++; if (lat !== 3) $display("FAIL load_latency got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata5 got %h want deadbeef", rd); else pass_cnt++;
    ls_txn(1'b0, 32'd9, 32'h0, lat, scyc, rd);
    total_cnt++; if (rd !== 32'h12345678) $display("FAIL load_rdata9 got %h want 12345678", rd); else pass_cnt++;
    total_cnt++; if (n_rd - r0 !== 2) $display("FAIL load_rd_cycles got %0d want 2", n_rd - r0); else pass_cnt++;
  endtask

  task automatic test_push_pop();
    int lat, scyc, p0, q0;
    logic [31:0] rd;
    logic err;
    logic [31:0] data_v [4] = '{32'd42, 32'd7, 32'd0, 32'd0};
    logic        push_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] rexp_v [4] = '{32'd0, 32'd0, 32'd7, 32'd42};
    logic [8:0]  sp_v   [4] = '{9'd1, 9'd2, 9'd1, 9'd0};
    p0 = n_push; q0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      st_txn(push_v[i], data_v[i], lat, scyc, rd, err);
      total_cnt++; if (lat !== 2 || err !== 1'b0 || scyc !== 1) $display("FAIL stack_op%0d lat/err/strobe got %0d/%b/%0d want 2/0/1", i, lat, err, scyc); else pass_cnt++;
      total_cnt++; if (sp_count !== sp_v[i]) $display("FAIL stack_sp%0d got %0d want %0d", i, sp_count, sp_v[i]); else pass_cnt++;
      if (!push_v[i]) begin
        total_cnt++; if (rd !== rexp_v[i]) $display("FAIL pop_rdata%0d got %0d want %0d", i, rd, rexp_v[i]); else pass_cnt++;
      end
    end
    total_cnt++; if (n_push - p0 !== 2 || n_pop - q0 !== 2) $display("FAIL stack_strobe_cycles got push %0d pop %0d want 2/2", n_push - p0, n_pop - q0); else pass_cnt++;
  endtask

  task automatic test_empty_pop();
    int lat, scyc, q0;
    logic [31:0] rd;
    logic err;
    q0 = n_pop;
    st_txn(1'b0, 32'h0, lat, scyc, rd, err);
    total_cnt++; if (lat !== 2 || err !== 1'b1) $display("FAIL empty_pop lat/err got %0d/%b want 2/1", lat, err); else pass_cnt++;
    total_cnt++; if (scyc !== -1 || n_pop !== q0) $display("FAIL empty_pop_strobe got cycle %0d count %0d want none", scyc, n_pop - q0); else pass_cnt++;
    total_cnt++; if (sp_count !== 9'd0) $display("FAIL empty_pop_sp got %0d want 0", sp_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    grant_seq_t: begin end
    begin
      logic [1:0] seq [4];
      int k = 0;
      logic [8:0] sp0;
      sp0 = sp_count;
      @(posedge clk); #1;
      ls_we = 1'b1; ls_addr = 32'd20; ls_wdata = 32'hA5A5_0001; ls_req = 1'b1;
      st_push = 1'b1; st_wdata = 32'h0000_0055; st_req = 1'b1;
      for (int n = 0; n < 40 && k < 4; n++) begin
        @(posedge clk); #1;
        if (ls_ack || st_ack) begin
          seq[k] = {ls_ack, st_ack};
          k++;
        end
      end
      ls_req = 1'b0; st_req = 1'b0;
      total_cnt++; if (k !== 4) $display("FAIL rr_ack_count got %0d want 4", k); else pass_cnt++;
      total_cnt++; if (k == 4 && {seq[0], seq[1], seq[2], seq[3]} !== 8'b10_01_10_01) $display("FAIL rr_order got %b want 10011001", {seq[0], seq[1], seq[2], seq[3]}); else if (k == 4) pass_cnt++;
      total_cnt++; if (multi_strobe !== 1'b0) $display("FAIL rr_single_strobe got overlap want none"); else pass_cnt++;
      total_cnt++; if (sp_count !== sp0 + 9'd2) $display("FAIL rr_sp got %0d want %0d", sp_count, sp0 + 9'd2); else pass_cnt++;
    end
  endtask

  task automatic test_full();
    int lat, scyc, errs, p0;
    logic [31:0] rd;
    logic err;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    errs = 0;
    for (int i = 1; i <= 511; i++) begin
      st_txn(1'b1, 32'(i), lat, scyc, rd, err);
      if (err !== 1'b0 || lat !== 2) errs++;
    end
    total_cnt++; if (errs !== 0 || sp_count !== 9'd511) $display("FAIL fill_stack got errs %0d sp %0d want 0/511", errs, sp_count); else pass_cnt++;
    p0 = n_push;
    st_txn(1'b1, 32'hFFFF, lat, scyc, rd, err);
    total_cnt++; if (lat !== 2 || err !== 1'b1) $display("FAIL full_push lat/err got %0d/%b want 2/1", lat, err); else pass_cnt++;
    total_cnt++; if (scyc !== -1 || n_push !== p0) $display("FAIL full_push_strobe got cycle %0d count %0d want none", scyc, n_push - p0); else pass_cnt++;
    total_cnt++; if (sp_count !== 9'd511) $display("FAIL full_push_sp got %0d want 511", sp_count); else pass_cnt++;
    st_txn(1'b0, 32'h0, lat, scyc, rd, err);
    total_cnt++; if (rd !== 32'd511 || err !== 1'b0 || sp_count !== 9'd510) $display("FAIL full_pop got %0d err %b sp %0d want 511/0/510", rd, err, sp_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    @(posedge clk); #1;
    ls_we = 1'b0; ls_addr = 32'd5; ls_req = 1'b1;
    @(posedge clk); #1;  // CMD
    @(posedge clk); #1;  // WAIT
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if ({mem_memoR, mem_memoWR, mem_push, mem_pop, ls_ack, st_ack} !== 6'b0) $display("FAIL mid_reset_outputs got %b want 000000", {mem_memoR, mem_memoWR, mem_push, mem_pop, ls_ack, st_ack}); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || sp_count !== 9'd0) $display("FAIL mid_reset_state got busy %b sp %0d want 0/0", busy, sp_count); else pass_cnt++;
    ls_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ls_ack || st_ack) acks++;
    end
    total_cnt++; if (acks !== 0) $display("FAIL mid_no_ack got %0d want 0", acks); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_push_pop();
    test_empty_pop();
    test_back_to_back();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
